// File: rtl/keysched_pkg.sv
// Shared constants and FSM encoding for the key-schedule arbiter.
package keysched_pkg;

  localparam int NR_DEF = 10;
  localparam int N_REQ  = 2;

  typedef enum logic [5:0] {
    ST_IDLE   = 6'b000001,
    ST_START  = 6'b000010,
    ST_EXPAND = 6'b000100,
    ST_HOLD   = 6'b001000,
    ST_FLUSH  = 6'b010000,
    ST_PARK   = 6'b100000
  } state_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter; pointer moves past the winner when upd is high.
module rr_arb2
  import keysched_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_REQ-1:0] req,
  input  logic             upd,
  output logic [N_REQ-1:0] gnt
);

  // ptr_q = 0 favours requester 0 on a tie
  logic ptr_q, ptr_d;

  always_comb begin
    gnt = req;
    if (&req) gnt = ptr_q ? 2'b10 : 2'b01;
    ptr_d = ptr_q;
    if (upd && (|gnt)) ptr_d = gnt[0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ptr_q <= 1'b0;
    else        ptr_q <= ptr_d;
  end

endmodule

// File: rtl/keysched_arb.sv
// Arbitrates two requesters onto one AES key-expansion engine.
// Optional key cache (PARK state) enabled by defining KEYSCHED_KEY_CACHE_EN.
module keysched_arb
  import keysched_pkg::*;
#(
  parameter int NR = NR_DEF
) (
  input  logic         iClk,
  input  logic         iRstN,
  input  logic         iReq0,
  input  logic         iReq1,
  input  logic [127:0] iKey0,
  input  logic [127:0] iKey1,
  input  logic         iRelease0,
  input  logic         iRelease1,
  output logic [1:0]   oGnt,
  output logic         oBusy,
  output logic         oStartKey,
  output logic         oEnd,
  output logic [127:0] oKey,
  input  logic [10:0]  iKeyRoundReady
);

  state_e       state_q, state_d;
  logic         sel_q, sel_d;
  logic [127:0] key_q, key_d;
  logic         abort_q, abort_d;

  logic [1:0]   req_vec;
  logic [1:0]   arb_gnt;
  logic         arb_upd;
  logic         win_sel;
  logic [127:0] win_key;
  logic         sel_req;
  logic         sel_rel;
  logic         unused_rdy;

  assign req_vec    = {iReq1, iReq0};
  assign win_sel    = arb_gnt[1];
  assign win_key    = arb_gnt[0] ? iKey0 : iKey1;
  assign sel_req    = sel_q ? iReq1 : iReq0;
  assign sel_rel    = sel_q ? iRelease1 : iRelease0;
  // Only the final round's ready bit matters; earlier bits are progress info
  assign unused_rdy = ^iKeyRoundReady;

  rr_arb2 u_rr (
    .clk   (iClk),
    .rst_n (iRstN),
    .req   (req_vec),
    .upd   (arb_upd),
    .gnt   (arb_gnt)
  );

`ifdef KEYSCHED_KEY_CACHE_EN
  logic cache_vld_q, cache_vld_d;
  logic key_hit;
  assign key_hit = cache_vld_q && (win_key == key_q);
`endif

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    key_d   = key_q;
    abort_d = abort_q;
    arb_upd = 1'b0;
`ifdef KEYSCHED_KEY_CACHE_EN
    cache_vld_d = cache_vld_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (|req_vec) begin
          arb_upd = 1'b1;
          sel_d   = win_sel;
          key_d   = win_key;
          abort_d = 1'b0;
          state_d = ST_START;
        end
      end
      ST_START: begin
        if (!sel_req) abort_d = 1'b1;
        state_d = ST_EXPAND;
      end
      ST_EXPAND: begin
        // A requester that let go at any point before completion gets no grant
        if (!sel_req) abort_d = 1'b1;
        if (iKeyRoundReady[NR]) state_d = (abort_q || !sel_req) ? ST_FLUSH : ST_HOLD;
      end
      ST_HOLD: begin
        if (sel_rel) begin
`ifdef KEYSCHED_KEY_CACHE_EN
          state_d     = ST_PARK;
          cache_vld_d = 1'b1;
`else
          state_d = ST_FLUSH;
`endif
        end
      end
      ST_FLUSH: begin
        state_d = ST_IDLE;
`ifdef KEYSCHED_KEY_CACHE_EN
        cache_vld_d = 1'b0;
`endif
      end
`ifdef KEYSCHED_KEY_CACHE_EN
      ST_PARK: begin
        if (|req_vec) begin
          if (key_hit) begin
            arb_upd = 1'b1;
            sel_d   = win_sel;
            state_d = ST_HOLD;
          end else begin
            // Miss: retire the parked schedule; IDLE re-arbitrates afterwards
            cache_vld_d = 1'b0;
            state_d     = ST_FLUSH;
          end
        end
      end
`endif
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge iClk or negedge iRstN) begin
    if (!iRstN) begin
      state_q <= ST_IDLE;
      sel_q   <= 1'b0;
      key_q   <= '0;
      abort_q <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      key_q   <= key_d;
      abort_q <= abort_d;
    end
  end

`ifdef KEYSCHED_KEY_CACHE_EN
  always_ff @(posedge iClk or negedge iRstN) begin
    if (!iRstN) cache_vld_q <= 1'b0;
    else        cache_vld_q <= cache_vld_d;
  end
`endif

  assign oGnt      = (state_q == ST_HOLD) ? (sel_q ? 2'b10 : 2'b01) : 2'b00;
  assign oBusy     = (state_q == ST_START) || (state_q == ST_EXPAND) ||
                     (state_q == ST_HOLD)  || (state_q == ST_FLUSH);
  assign oStartKey = (state_q == ST_START);
  assign oEnd      = (state_q == ST_FLUSH);
  assign oKey      = key_q;

endmodule

// File: tb/tb_keysched_arb.sv
// Self-checking bench for keysched_arb: directed scenarios plus randomized
// requesters, all compared every cycle against a transaction-level model.
module tb_keysched_arb;

  localparam logic [127:0] K0 = 128'h2b7e1516_28aed2a6_abf71588_09cf4f3c;
  localparam logic [127:0] K1 = 128'h00112233_44556677_8899aabb_ccddeeff;
  localparam logic [127:0] K2 = 128'hdeadbeef_01234567_89abcdef_feedface;

  localparam int P_IDLE = 0, P_START = 1, P_EXP = 2, P_HOLD = 3, P_FLUSH = 4, P_PARK = 5;

  logic         iClk = 1'b0;
  logic         iRstN;
  logic         req_a [2];
  logic         rel_a [2];
  logic [127:0] key_a [2];
  logic [1:0]   oGnt;
  logic         oBusy, oStartKey, oEnd;
  logic [127:0] oKey;
  logic [10:0]  iKeyRoundReady;

  wire          iReq0     = req_a[0];
  wire          iReq1     = req_a[1];
  wire          iRelease0 = rel_a[0];
  wire          iRelease1 = rel_a[1];
  wire  [127:0] iKey0     = key_a[0];
  wire  [127:0] iKey1     = key_a[1];

  always #5 iClk = ~iClk;

  keysched_arb dut (
    .iClk           (iClk),
    .iRstN          (iRstN),
    .iReq0          (iReq0),
    .iReq1          (iReq1),
    .iKey0          (iKey0),
    .iKey1          (iKey1),
    .iRelease0      (iRelease0),
    .iRelease1      (iRelease1),
    .oGnt           (oGnt),
    .oBusy          (oBusy),
    .oStartKey      (oStartKey),
    .oEnd           (oEnd),
    .oKey           (oKey),
    .iKeyRoundReady (iKeyRoundReady)
  );

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
  endtask

  // ---------------- reference model ----------------
  int           m_ph, m_own, m_last;
  logic [127:0] m_key;
  bit           m_abort;

  task automatic model_reset();
    m_ph = P_IDLE; m_own = 0; m_last = 1; m_key = '0; m_abort = 0;
  endtask

  function automatic int pick(bit r0, bit r1);
    if (r0 && r1) return 1 - m_last;
    return r1 ? 1 : 0;
  endfunction

  task automatic model_step();
    bit r0, r1, own_req, own_rel;
    int w;
    logic [127:0] wk;
    r0 = iReq0; r1 = iReq1;
    own_req = (m_own == 1) ? iReq1 : iReq0;
    own_rel = (m_own == 1) ? iRelease1 : iRelease0;
    w  = pick(r0, r1);
    wk = (w == 1) ? iKey1 : iKey0;
    case (m_ph)
      P_IDLE:  if (r0 || r1) begin m_last = w; m_own = w; m_key = wk; m_abort = 0; m_ph = P_START; end
      P_START: begin if (!own_req) m_abort = 1; m_ph = P_EXP; end
      P_EXP: begin
        if (!own_req) m_abort = 1;
        if (iKeyRoundReady[10]) m_ph = m_abort ? P_FLUSH : P_HOLD;
      end
      P_HOLD: if (own_rel) begin
`ifdef KEYSCHED_KEY_CACHE_EN
        m_ph = P_PARK;
`else
        m_ph = P_FLUSH;
`endif
      end
      P_FLUSH: m_ph = P_IDLE;
      P_PARK: if (r0 || r1) begin
        if (wk == m_key) begin m_last = w; m_own = w; m_ph = P_HOLD; end
        else m_ph = P_FLUSH;
      end
      default: m_ph = P_IDLE;
    endcase
  endtask

  // ---------------- environment ----------------
  int  cyc = 0, rdy_cyc = 0, gnt_cyc = 0;
  int  n_start = 0, n_end = 0;
  int  lat = 4;
  int  eng_cnt = 0;
  bit  eng_act = 0;
  bit  rand_on = 0;
  int  a_st [2];
  int  a_cnt [2];

  function automatic logic [127:0] rand_key();
    return ($urandom_range(0, 1) == 0) ? K0 : K1;
  endfunction

  task automatic agent(input int i);
    rel_a[i] = 1'b0;
    case (a_st[i])
      0: begin
        if ($urandom_range(0, 19) == 0) rel_a[i] = 1'b1;
        if ($urandom_range(0, 3) == 0) begin req_a[i] = 1'b1; key_a[i] = rand_key(); a_st[i] = 1; end
      end
      1: begin
        if (oGnt[i]) begin req_a[i] = 1'b0; a_st[i] = 2; a_cnt[i] = int'($urandom_range(0, 3)); end
        else if ($urandom_range(0, 39) == 0) begin req_a[i] = 1'b0; a_st[i] = 0; end
      end
      default: begin
        if (a_cnt[i] == 0) begin
          rel_a[i] = 1'b1; a_st[i] = 0;
          if ($urandom_range(0, 2) == 0) begin req_a[i] = 1'b1; key_a[i] = rand_key(); a_st[i] = 1; end
        end else a_cnt[i]--;
      end
    endcase
  endtask

  task automatic tick();
    bit done;
    @(posedge iClk);
    if (!iRstN) model_reset(); else model_step();
    cyc++;
    #1;
    chk("gnt",   128'(oGnt),      128'((m_ph == P_HOLD) ? ((m_own == 1) ? 2'b10 : 2'b01) : 2'b00));
    chk("busy",  128'(oBusy),     128'(m_ph == P_START || m_ph == P_EXP || m_ph == P_HOLD || m_ph == P_FLUSH));
    chk("start", 128'(oStartKey), 128'(m_ph == P_START));
    chk("end",   128'(oEnd),      128'(m_ph == P_FLUSH));
    chk("key",   oKey,            m_key);
    if (oStartKey) n_start++;
    if (oEnd) n_end++;
    if (!iRstN || oEnd) eng_act = 0;
    else if (oStartKey) begin
      if (rand_on) lat = int'($urandom_range(2, 14));
      eng_act = 1; eng_cnt = lat;
    end else if (eng_act && eng_cnt > 0) eng_cnt--;
    done = eng_act && (eng_cnt == 0);
    if (done && !iKeyRoundReady[10]) rdy_cyc = cyc;
    iKeyRoundReady = done ? 11'h7ff : (eng_act ? (11'h3ff >> eng_cnt) : 11'h000);
    if (rand_on) for (int i = 0; i < 2; i++) agent(i);
  endtask

  task automatic assert_rst();
    iRstN = 1'b0;
    req_a[0] = 1'b0; req_a[1] = 1'b0; rel_a[0] = 1'b0; rel_a[1] = 1'b0;
    #1;
    chk("rst_gnt",   128'(oGnt),      128'(0));
    chk("rst_busy",  128'(oBusy),     128'(0));
    chk("rst_start", 128'(oStartKey), 128'(0));
    chk("rst_end",   128'(oEnd),      128'(0));
    chk("rst_key",   oKey,            128'(0));
    model_reset();
    eng_act = 0; iKeyRoundReady = '0;
  endtask

  task automatic do_reset();
    assert_rst();
    tick(); tick();
    iRstN = 1'b1;
    tick();
  endtask

  task automatic wait_gnt(input int bound, output logic [1:0] g);
    g = 2'b00;
    for (int i = 0; i < bound; i++) begin
      tick();
      if (oGnt != 2'b00) begin g = oGnt; gnt_cyc = cyc; return; end
    end
    chk("gnt_timeout", 128'(1), 128'(0));
  endtask

  task automatic wait_start(input int bound);
    for (int i = 0; i < bound; i++) begin
      tick();
      if (oStartKey) return;
    end
    chk("start_timeout", 128'(1), 128'(0));
  endtask

  task automatic pulse_rel(input int i, input bit rereq);
    rel_a[i] = 1'b1;
    if (rereq) req_a[i] = 1'b1;
    tick();
    rel_a[i] = 1'b0;
  endtask

  initial begin
    logic [1:0] g;
    int s0, e0, c0;
    bit any_g;
    iRstN = 1'b0;
    req_a[0] = 0; req_a[1] = 0; rel_a[0] = 0; rel_a[1] = 0;
    key_a[0] = '0; key_a[1] = '0;
    iKeyRoundReady = '0;
    a_st[0] = 0; a_st[1] = 0; a_cnt[0] = 0; a_cnt[1] = 0;
    model_reset();
    do_reset();

    // single request, engine ready after 11 cycles
    lat = 11; s0 = n_start; e0 = n_end;
    key_a[0] = K0; req_a[0] = 1'b1;
    wait_gnt(40, g);
    chk("single_gnt", 128'(g), 128'(2'b01));
    chk("single_lat", 128'(gnt_cyc - rdy_cyc), 128'(1));
    chk("single_key", oKey, K0);
    req_a[0] = 1'b0;
    tick();
    pulse_rel(0, 0);
    repeat (3) tick();
    chk("single_starts", 128'(n_start - s0), 128'(1));
`ifdef KEYSCHED_KEY_CACHE_EN
    chk("single_ends", 128'(n_end - e0), 128'(0));
`else
    chk("single_ends", 128'(n_end - e0), 128'(1));
`endif
    chk("single_busy", 128'(oBusy), 128'(0));

    // contention, round-robin alternation, release+re-request same cycle
    do_reset();
    lat = 4; key_a[0] = K0; key_a[1] = K1;
    req_a[0] = 1'b1; req_a[1] = 1'b1;
    wait_gnt(40, g);
    chk("rr_first", 128'(g), 128'(2'b01));
    req_a[0] = 1'b0; tick();
    pulse_rel(0, 1);
    wait_gnt(40, g);
    chk("rr_second", 128'(g), 128'(2'b10));
    req_a[1] = 1'b0; tick();
    pulse_rel(1, 1);
    wait_gnt(40, g);
    chk("rr_third", 128'(g), 128'(2'b01));

    // abort: requester 1 drops 3 cycles into EXPAND
    do_reset();
    lat = 10; e0 = n_end; key_a[1] = K1; req_a[1] = 1'b1;
    wait_start(20);
    repeat (3) tick();
    req_a[1] = 1'b0;
    any_g = 0;
    repeat (14) begin tick(); if (oGnt != 2'b00) any_g = 1; end
    chk("abort_nogrant", 128'(any_g), 128'(0));
    chk("abort_ends", 128'(n_end - e0), 128'(1));
    chk("abort_busy", 128'(oBusy), 128'(0));

`ifdef KEYSCHED_KEY_CACHE_EN
    // cache hit then cache miss
    do_reset();
    lat = 5; key_a[0] = K0; req_a[0] = 1'b1;
    wait_gnt(40, g);
    req_a[0] = 1'b0; tick();
    pulse_rel(0, 0); tick();
    s0 = n_start; req_a[0] = 1'b1; c0 = cyc;
    wait_gnt(10, g);
    chk("cache_hit_gnt", 128'(g), 128'(2'b01));
    chk("cache_hit_lat", 128'(gnt_cyc - c0), 128'(1));
    chk("cache_hit_starts", 128'(n_start - s0), 128'(0));
    req_a[0] = 1'b0; tick();
    pulse_rel(0, 0); tick();
    s0 = n_start; e0 = n_end; key_a[0] = K2; req_a[0] = 1'b1;
    wait_gnt(40, g);
    chk("cache_miss_gnt", 128'(g), 128'(2'b01));
    chk("cache_miss_ends", 128'(n_end - e0), 128'(1));
    chk("cache_miss_starts", 128'(n_start - s0), 128'(1));
    chk("cache_miss_key", oKey, K2);
    req_a[0] = 1'b0;
`endif

    // reset while holding a grant
    do_reset();
    lat = 3; key_a[0] = K0; req_a[0] = 1'b1;
    wait_gnt(40, g);
    chk("hold_gnt", 128'(g), 128'(2'b01));
    req_a[0] = 1'b0; tick();
    #2;
    assert_rst();
    tick();
    iRstN = 1'b1; key_a[1] = K1; req_a[1] = 1'b1;
    tick();
    chk("post_rst_nostale", 128'(oGnt), 128'(0));
    wait_gnt(40, g);
    chk("post_rst_gnt", 128'(g), 128'(2'b10));

    // randomized traffic
    do_reset();
    rand_on = 1;
    repeat (3000) tick();
    rand_on = 0;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got %0d checks, want completion", n_chk);
    $fatal(1);
  end

endmodule
